// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one programmable divide counter among NUM_REQ requesters.
// The owner gets a tick strobe per divide period and a ~50% duty div_clk.
module divider_arbiter #(
  parameter int unsigned NUM_REQ         = 3,
  parameter int unsigned DIV_W           = 16,
  parameter int unsigned TICKS_PER_GRANT = 8
) (
  input  logic                     clock_in,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*DIV_W-1:0] div_in,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       tick_out,
  output logic [NUM_REQ-1:0]       err,
  output logic                     div_clk,
  output logic                     busy
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic [DIV_W-1:0]  TickLast = DIV_W'(TICKS_PER_GRANT - 1);
  localparam logic [PtrW:0]     NumReqW  = (PtrW+1)'(NUM_REQ);

  logic [0:0]         state_q, state_d;
  logic [PtrW-1:0]    sel_q, sel_d;
  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   tcnt_q, tcnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] tick_q, tick_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               dclk_q, dclk_d;
  logic               busy_q, busy_d;

  logic               win_found;
  logic [PtrW-1:0]    win_idx;
  logic [PtrW-1:0]    win_nxt;
  logic [DIV_W-1:0]   win_div;
  logic [NUM_REQ-1:0] sel_oh;
  logic               others;
  logic               period_end;

  // Scan from the farthest offset down so the entry nearest ptr is the last one written.
  always_comb begin
    logic [PtrW:0] sum;
    logic [PtrW:0] nxt;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + (PtrW+1)'(k);
      if (sum >= NumReqW) sum = sum - NumReqW;
      if (req[sum[PtrW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = sum[PtrW-1:0];
      end
    end
    win_div = div_in[int'(win_idx)*DIV_W +: DIV_W];
    nxt     = {1'b0, win_idx} + (PtrW+1)'(1);
    if (nxt >= NumReqW) nxt = '0;
    win_nxt = nxt[PtrW-1:0];
  end

  always_comb begin
    sel_oh     = NUM_REQ'(1) << sel_q;
    others     = |(req & ~sel_oh);
    period_end = (cnt_q == div_q - DIV_W'(1));
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    grant_d = grant_q;
    dclk_d  = dclk_q;
    busy_d  = busy_q;
    tick_d  = '0;
    err_d   = '0;

    case (state_q)
      StIdle: begin
        grant_d = '0;
        busy_d  = 1'b0;
        dclk_d  = 1'b0;
        cnt_d   = '0;
        if (win_found) begin
          ptr_d = win_nxt;
          if (win_div != '0) begin
            state_d = StRun;
            sel_d   = win_idx;
            div_d   = win_div;
            tcnt_d  = '0;
            grant_d = NUM_REQ'(1) << win_idx;
            busy_d  = 1'b1;
            dclk_d  = (win_div > DIV_W'(1));
          end else begin
            err_d[win_idx] = 1'b1;
          end
        end
      end
      StRun: begin
        if (period_end) begin
          tick_d = sel_oh;
          cnt_d  = '0;
          tcnt_d = (tcnt_q == TickLast) ? '0 : tcnt_q + DIV_W'(1);
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
        // Release and preempt both land in IDLE; a completed period still ticks.
        if (!req[sel_q] || (period_end && (tcnt_q == TickLast) && others)) begin
          state_d = StIdle;
          grant_d = '0;
          busy_d  = 1'b0;
          dclk_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          dclk_d = (cnt_d < (div_q >> 1));
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q <= StIdle;
      sel_q   <= '0;
      ptr_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      grant_q <= '0;
      tick_q  <= '0;
      err_q   <= '0;
      dclk_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      grant_q <= grant_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
      dclk_q  <= dclk_d;
      busy_q  <= busy_d;
    end
  end

  assign grant    = grant_q;
  assign tick_out = tick_q;
  assign err      = err_q;
  assign div_clk  = dclk_q;
  assign busy     = busy_q;

endmodule
